// File: rtl/npu_pkg.sv
// npu_pkg: shared definitions for the NPU job launcher.
//   npu_state_t   : launcher FSM state encoding (also exposed on DBG_STATE)
//   *_LSB         : bit offsets of the operand fields inside CMD_DATA
//   OP_W, CMD_W   : operand byte width and command word width
//   JOB_CNT_W     : width of the completed-job counter
package npu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } npu_state_t;

  localparam int OP_W      = 8;
  localparam int CMD_W     = 40;
  localparam int JOB_CNT_W = 16;

  localparam int DA_LSB    = 0;
  localparam int DB_LSB    = 8;
  localparam int DC_LSB    = 16;
  localparam int DD_LSB    = 24;
  localparam int BIAS_LSB  = 32;

endpackage

// File: rtl/npu_res_fifo.sv
// npu_res_fifo: synchronous result FIFO, DEPTH entries of WIDTH bits.
// Ports:
//   clk, rst         : clock, synchronous active-high reset (empties FIFO)
//   push, push_data  : write request and data
//   pop, pop_data    : read request; pop_data is the head (0 when empty)
//   count            : current occupancy, 0..DEPTH
//   full, empty      : occupancy flags
// Handshake: a push or pop happens on the edge where it is requested and
// legal. A pop on an empty FIFO is ignored; a push into a full FIFO is
// accepted only when a pop frees the head slot on the same edge.
module npu_res_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Head is forced to 0 when empty so the output is defined after reset
  // even though the storage array itself is not reset.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/npu_job_launcher.sv
// npu_job_launcher: accepts a job command, launches it on the NPU with a
// one-cycle start pulse, waits for completion and queues the result.
// Optional feature macro: NPU_LAUNCH_TIMEOUT_EN (WAIT watchdog, sticky ERR).
// Ports:
//   CLKEXT, RST_GLO            : clock, synchronous active-high reset
//   CMD_VALID/READY/DATA       : command stream {BIAS,DD,DC,DB,DA}
//   NPU_DA..NPU_BIAS           : registered operands to the NPU
//   NPU_START                  : one-cycle launch pulse
//   NPU_BUSY, NPU_DONE, NPU_D_OUT : NPU status and result
//   RES_VALID/READY/DATA       : result stream out of the FIFO
//   BUSY, JOB_CNT, ERR         : launcher status
//   DBG_STATE, DBG_RES_COUNT   : FSM state and FIFO occupancy for debug
// Handshake: a transfer on either stream happens on a rising edge where
// VALID and READY are both 1; VALID never depends on READY.
module npu_job_launcher
  import npu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int RES_DEPTH      = 4
) (
  input  logic                         CLKEXT,
  input  logic                         RST_GLO,
  input  logic                         CMD_VALID,
  output logic                         CMD_READY,
  input  logic [CMD_W-1:0]             CMD_DATA,
  output logic [OP_W-1:0]              NPU_DA,
  output logic [OP_W-1:0]              NPU_DB,
  output logic [OP_W-1:0]              NPU_DC,
  output logic [OP_W-1:0]              NPU_DD,
  output logic [OP_W-1:0]              NPU_BIAS,
  output logic                         NPU_START,
  input  logic                         NPU_BUSY,
  input  logic                         NPU_DONE,
  input  logic [OP_W-1:0]              NPU_D_OUT,
  output logic                         RES_VALID,
  input  logic                         RES_READY,
  output logic [OP_W-1:0]              RES_DATA,
  output logic                         BUSY,
  output logic [JOB_CNT_W-1:0]         JOB_CNT,
  output logic                         ERR,
  output npu_state_t                   DBG_STATE,
  output logic [$clog2(RES_DEPTH):0]   DBG_RES_COUNT
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  if (RES_DEPTH < 2 || (RES_DEPTH & (RES_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("RES_DEPTH must be a power of 2 and at least 2");
  end

  npu_state_t       state;
  npu_state_t       state_n;
  logic [CMD_W-1:0] op_q;
  logic             accept;
  logic             done_ok;
  logic             timeout;
  logic             res_full;
  logic             res_empty;
  logic             unused_npu_busy;

  // NPU_BUSY is only observed, never used for control.
  assign unused_npu_busy = NPU_BUSY;

  assign CMD_READY = (state == ST_IDLE) && !res_full;
  assign accept    = CMD_VALID && CMD_READY;
  assign done_ok   = (state == ST_WAIT) && NPU_DONE;
  assign NPU_START = (state == ST_LAUNCH);
  assign BUSY      = (state != ST_IDLE);
  assign RES_VALID = !res_empty;
  assign DBG_STATE = state;

  assign NPU_DA    = op_q[DA_LSB   +: OP_W];
  assign NPU_DB    = op_q[DB_LSB   +: OP_W];
  assign NPU_DC    = op_q[DC_LSB   +: OP_W];
  assign NPU_DD    = op_q[DD_LSB   +: OP_W];
  assign NPU_BIAS  = op_q[BIAS_LSB +: OP_W];

`ifdef NPU_LAUNCH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wait_cnt;
  logic            err_q;

  // wait_cnt holds the number of WAIT cycles already completed; the
  // watchdog fires at the end of the TIMEOUT_CYCLES-th one. A DONE on that
  // same cycle still wins.
  assign timeout = (state == ST_WAIT) && !NPU_DONE &&
                   (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign ERR     = err_q;

  always_ff @(posedge CLKEXT) begin
    if (RST_GLO) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      wait_cnt <= (state == ST_WAIT && !timeout) ? wait_cnt + 1'b1 : '0;
      if (timeout) err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign ERR     = 1'b0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (accept) state_n = ST_LAUNCH;
      ST_LAUNCH: state_n = ST_WAIT;
      ST_WAIT:   if (NPU_DONE || timeout) state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLKEXT) begin
    if (RST_GLO) begin
      state   <= ST_IDLE;
      op_q    <= '0;
      JOB_CNT <= '0;
    end else begin
      state <= state_n;
      if (accept)  op_q    <= CMD_DATA;
      if (done_ok) JOB_CNT <= JOB_CNT + 1'b1;
    end
  end

  npu_res_fifo #(
    .DEPTH (RES_DEPTH),
    .WIDTH (OP_W)
  ) u_res_fifo (
    .clk       (CLKEXT),
    .rst       (RST_GLO),
    .push      (done_ok),
    .push_data (NPU_D_OUT),
    .pop       (RES_READY),
    .pop_data  (RES_DATA),
    .count     (DBG_RES_COUNT),
    .full      (res_full),
    .empty     (res_empty)
  );

endmodule

// File: tb/tb_npu_job_launcher.sv
// tb_npu_job_launcher: self-checking bench for npu_job_launcher.
// The reference model works at job level: a queue of expected result bytes
// and an expected job count, updated whenever a job completes or a result
// is drained. Build with NPU_LAUNCH_TIMEOUT_EN to exercise the watchdog.
module tb_npu_job_launcher;
  import npu_pkg::*;

  localparam int DEPTH = 4;
  localparam int TO    = 16;

  logic        CLKEXT = 1'b0;
  logic        RST_GLO = 1'b0;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic [39:0] CMD_DATA = '0;
  logic [7:0]  NPU_DA, NPU_DB, NPU_DC, NPU_DD, NPU_BIAS;
  logic        NPU_START;
  logic        NPU_BUSY = 1'b0;
  logic        NPU_DONE = 1'b0;
  logic [7:0]  NPU_D_OUT = '0;
  logic        RES_VALID;
  logic        RES_READY = 1'b0;
  logic [7:0]  RES_DATA;
  logic        BUSY;
  logic [15:0] JOB_CNT;
  logic        ERR;
  npu_state_t  DBG_STATE;
  logic [2:0]  DBG_RES_COUNT;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] exp_cnt = '0;

  // clock / reset block
  always #5 CLKEXT = ~CLKEXT;

  npu_job_launcher #(.TIMEOUT_CYCLES(TO), .RES_DEPTH(DEPTH)) dut (
    .CLKEXT(CLKEXT), .RST_GLO(RST_GLO),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_DATA(CMD_DATA),
    .NPU_DA(NPU_DA), .NPU_DB(NPU_DB), .NPU_DC(NPU_DC), .NPU_DD(NPU_DD),
    .NPU_BIAS(NPU_BIAS), .NPU_START(NPU_START),
    .NPU_BUSY(NPU_BUSY), .NPU_DONE(NPU_DONE), .NPU_D_OUT(NPU_D_OUT),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA),
    .BUSY(BUSY), .JOB_CNT(JOB_CNT), .ERR(ERR),
    .DBG_STATE(DBG_STATE), .DBG_RES_COUNT(DBG_RES_COUNT)
  );

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge CLKEXT);
    #1;
  endtask

  task automatic do_reset();
    RST_GLO = 1'b1; CMD_VALID = 1'b0; NPU_DONE = 1'b0; RES_READY = 1'b0;
    NPU_BUSY = 1'b0;
    tick(); tick();
    RST_GLO = 1'b0;
    exp_q.delete();
    exp_cnt = '0;
  endtask

  // driver: one complete job with k WAIT cycles before DONE; optionally pop
  // the head on the same edge as the push.
  task automatic run_job(input logic [39:0] cmd, input int k,
                         input logic [7:0] dout, input bit pop_on_done);
    logic [39:0] ops;
    n_tests++;
    if (CMD_READY !== 1'b1) begin
      n_fail++; $display("FAIL job_cmd_ready got %b want 1", CMD_READY);
    end
    CMD_VALID = 1'b1; CMD_DATA = cmd;
    tick();
    CMD_VALID = 1'b0; CMD_DATA = {$urandom, 8'h00};
    ops = {NPU_BIAS, NPU_DD, NPU_DC, NPU_DB, NPU_DA};
    n_tests++;
    if (NPU_START !== 1'b1 || BUSY !== 1'b1 || ops !== cmd) begin
      n_fail++;
      $display("FAIL job_launch start=%b busy=%b ops=%h want 1 1 %h",
               NPU_START, BUSY, ops, cmd);
    end
    tick();
    NPU_BUSY = 1'b1;
    for (int i = 0; i <= k; i++) begin
      ops = {NPU_BIAS, NPU_DD, NPU_DC, NPU_DB, NPU_DA};
      n_tests++;
      if (NPU_START !== 1'b0 || BUSY !== 1'b1 || ops !== cmd ||
          DBG_STATE !== ST_WAIT) begin
        n_fail++;
        $display("FAIL job_wait start=%b busy=%b ops=%h st=%0d want 0 1 %h %0d",
                 NPU_START, BUSY, ops, DBG_STATE, cmd, ST_WAIT);
      end
      if (i < k) tick();
    end
    NPU_DONE = 1'b1; NPU_D_OUT = dout;
    if (pop_on_done) begin
      n_tests++;
      if (RES_VALID !== 1'b1 || RES_DATA !== exp_q[0]) begin
        n_fail++;
        $display("FAIL job_pop_head valid=%b data=%h want 1 %h",
                 RES_VALID, RES_DATA, exp_q[0]);
      end
      RES_READY = 1'b1;
    end
    tick();
    if (pop_on_done) void'(exp_q.pop_front());
    exp_q.push_back(dout);
    exp_cnt = exp_cnt + 16'd1;
    NPU_DONE = 1'b0; NPU_BUSY = 1'b0; RES_READY = 1'b0;
    n_tests++;
    if (JOB_CNT !== exp_cnt || BUSY !== 1'b0 ||
        DBG_RES_COUNT !== 3'(exp_q.size()) || RES_DATA !== exp_q[0]) begin
      n_fail++;
      $display("FAIL job_done cnt=%0d busy=%b occ=%0d head=%h want %0d 0 %0d %h",
               JOB_CNT, BUSY, DBG_RES_COUNT, RES_DATA, exp_cnt, exp_q.size(), exp_q[0]);
    end
  endtask

  // driver: pop one result and compare against the scoreboard head
  task automatic drain_one();
    n_tests++;
    if (RES_VALID !== 1'b1 || RES_DATA !== exp_q[0]) begin
      n_fail++;
      $display("FAIL drain valid=%b data=%h want 1 %h", RES_VALID, RES_DATA, exp_q[0]);
    end
    RES_READY = 1'b1;
    tick();
    RES_READY = 1'b0;
    void'(exp_q.pop_front());
  endtask

  task automatic drain_all();
    while (exp_q.size() > 0) drain_one();
    n_tests++;
    if (RES_VALID !== 1'b0 || DBG_RES_COUNT !== 3'd0) begin
      n_fail++;
      $display("FAIL drain_empty valid=%b occ=%0d want 0 0", RES_VALID, DBG_RES_COUNT);
    end
  endtask

  task automatic test_reset();
    RST_GLO = 1'b1;
    tick();
    n_tests++;
    if ({NPU_BIAS, NPU_DD, NPU_DC, NPU_DB, NPU_DA} !== 40'd0 || NPU_START !== 1'b0 ||
        BUSY !== 1'b0 || ERR !== 1'b0 || JOB_CNT !== 16'd0 ||
        RES_VALID !== 1'b0 || RES_DATA !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_outputs ops=%h st=%b busy=%b err=%b cnt=%0d rv=%b rd=%h want all 0",
               {NPU_BIAS, NPU_DD, NPU_DC, NPU_DB, NPU_DA}, NPU_START, BUSY, ERR,
               JOB_CNT, RES_VALID, RES_DATA);
    end
    RST_GLO = 1'b0;
    tick();
    n_tests++;
    if (CMD_READY !== 1'b1 || DBG_STATE !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_release cmd_ready=%b st=%0d want 1 0", CMD_READY, DBG_STATE);
    end
    exp_q.delete();
    exp_cnt = '0;
  endtask

  task automatic test_basic_job();
    do_reset();
    run_job(40'h05_04_03_02_01, 4, 8'h3C, 1'b0);
    n_tests++;
    if (RES_DATA !== 8'h3C || JOB_CNT !== 16'd1) begin
      n_fail++;
      $display("FAIL basic_result data=%h cnt=%0d want 3c 1", RES_DATA, JOB_CNT);
    end
    drain_all();
  endtask

  task automatic test_random_jobs();
    do_reset();
    for (int j = 0; j < 12; j++) begin
      if (exp_q.size() == DEPTH) drain_one();
      run_job({$urandom, 8'($urandom)}, $urandom_range(0, 6), 8'($urandom), 1'b0);
      if ($urandom_range(0, 1) == 1) drain_one();
    end
    drain_all();
  endtask

  task automatic test_fifo_full();
    do_reset();
    for (int j = 0; j < DEPTH; j++)
      run_job({$urandom, 8'($urandom)}, $urandom_range(0, 3), 8'($urandom), 1'b0);
    CMD_VALID = 1'b1; CMD_DATA = 40'hAA_BB_CC_DD_EE;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (CMD_READY !== 1'b0 || BUSY !== 1'b0) begin
        n_fail++;
        $display("FAIL full_blocks cmd_ready=%b busy=%b want 0 0", CMD_READY, BUSY);
      end
      tick();
    end
    CMD_VALID = 1'b0;
    drain_one();
    n_tests++;
    if (CMD_READY !== 1'b1) begin
      n_fail++; $display("FAIL full_reopen cmd_ready=%b want 1", CMD_READY);
    end
    drain_all();
  endtask

  task automatic test_simul_push_pop();
    do_reset();
    run_job(40'h11_22_33_44_55, 1, 8'hA1, 1'b0);
    run_job(40'h66_77_88_99_AA, 0, 8'hA2, 1'b0);
    run_job(40'h01_02_03_04_05, 2, 8'hA3, 1'b1);
    n_tests++;
    if (DBG_RES_COUNT !== 3'd2 || RES_DATA !== 8'hA2) begin
      n_fail++;
      $display("FAIL simul_occ occ=%0d head=%h want 2 a2", DBG_RES_COUNT, RES_DATA);
    end
    drain_all();
  endtask

  task automatic test_done_ignored();
    do_reset();
    run_job(40'h10_20_30_40_50, 0, 8'h5A, 1'b0);
    NPU_DONE = 1'b1; NPU_D_OUT = 8'hEE;
    tick(); tick();
    NPU_DONE = 1'b0;
    n_tests++;
    if (JOB_CNT !== exp_cnt || DBG_RES_COUNT !== 3'(exp_q.size())) begin
      n_fail++;
      $display("FAIL done_in_idle cnt=%0d occ=%0d want %0d %0d",
               JOB_CNT, DBG_RES_COUNT, exp_cnt, exp_q.size());
    end
    // DONE held through LAUNCH is ignored there and counted only in WAIT
    CMD_VALID = 1'b1; CMD_DATA = 40'h0F_0E_0D_0C_0B;
    tick();
    CMD_VALID = 1'b0; NPU_DONE = 1'b1; NPU_D_OUT = 8'h77;
    tick();
    n_tests++;
    if (JOB_CNT !== exp_cnt || DBG_STATE !== ST_WAIT) begin
      n_fail++;
      $display("FAIL done_in_launch cnt=%0d st=%0d want %0d %0d",
               JOB_CNT, DBG_STATE, exp_cnt, ST_WAIT);
    end
    tick();
    NPU_DONE = 1'b0;
    exp_q.push_back(8'h77);
    exp_cnt = exp_cnt + 16'd1;
    n_tests++;
    if (JOB_CNT !== exp_cnt || DBG_RES_COUNT !== 3'(exp_q.size())) begin
      n_fail++;
      $display("FAIL done_in_wait cnt=%0d occ=%0d want %0d %0d",
               JOB_CNT, DBG_RES_COUNT, exp_cnt, exp_q.size());
    end
    drain_all();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    CMD_VALID = 1'b1; CMD_DATA = 40'h12_34_56_78_9A;
    tick();
    CMD_VALID = 1'b0;
    tick(); tick(); tick();
    RST_GLO = 1'b1;
    tick();
    RST_GLO = 1'b0;
    NPU_DONE = 1'b1; NPU_D_OUT = 8'h99;
    tick(); tick();
    NPU_DONE = 1'b0;
    n_tests++;
    if (RES_VALID !== 1'b0 || JOB_CNT !== 16'd0 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_wait rv=%b cnt=%0d busy=%b want 0 0 0",
               RES_VALID, JOB_CNT, BUSY);
    end
    exp_q.delete();
    exp_cnt = '0;
  endtask

  task automatic test_timeout();
    do_reset();
    CMD_VALID = 1'b1; CMD_DATA = 40'hDE_AD_BE_EF_01;
    tick();
    CMD_VALID = 1'b0;
    tick();
    for (int i = 0; i < TO - 1; i++) tick();
    n_tests++;
    if (BUSY !== 1'b1 || ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_before busy=%b err=%b want 1 0", BUSY, ERR);
    end
    tick();
`ifdef NPU_LAUNCH_TIMEOUT_EN
    n_tests++;
    if (ERR !== 1'b1 || DBG_STATE !== ST_IDLE || RES_VALID !== 1'b0 ||
        JOB_CNT !== exp_cnt) begin
      n_fail++;
      $display("FAIL timeout_fire err=%b st=%0d rv=%b cnt=%0d want 1 0 0 %0d",
               ERR, DBG_STATE, RES_VALID, JOB_CNT, exp_cnt);
    end
    run_job(40'h01_01_01_01_01, 1, 8'h42, 1'b0);
    n_tests++;
    if (ERR !== 1'b1) begin
      n_fail++; $display("FAIL timeout_sticky err=%b want 1", ERR);
    end
    drain_all();
`else
    for (int i = 0; i < 2 * TO; i++) tick();
    n_tests++;
    if (ERR !== 1'b0 || DBG_STATE !== ST_WAIT || BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL no_timeout err=%b st=%0d busy=%b want 0 %0d 1",
               ERR, DBG_STATE, BUSY, ST_WAIT);
    end
    NPU_DONE = 1'b1; NPU_D_OUT = 8'h42;
    tick();
    NPU_DONE = 1'b0;
    exp_q.push_back(8'h42);
    exp_cnt = exp_cnt + 16'd1;
    n_tests++;
    if (JOB_CNT !== exp_cnt || RES_DATA !== 8'h42) begin
      n_fail++;
      $display("FAIL late_done cnt=%0d data=%h want %0d 42", JOB_CNT, RES_DATA, exp_cnt);
    end
    drain_all();
`endif
  endtask

  initial begin
    test_reset();
    test_basic_job();
    test_random_jobs();
    test_fifo_full();
    test_simul_push_pop();
    test_done_ignored();
    test_reset_mid_wait();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/npu_job_launcher.md
NPU_JOB_LAUNCHER -- requirements
Module: npu_job_launcher

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 1024: the watchdog limit in cycles spent in WAIT.
REQ-002 The module SHALL have parameter RES_DEPTH, default 4: result FIFO depth, a power of 2 and at least 2.
REQ-003 The module SHALL have port CLKEXT, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port RST_GLO, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have ports CMD_VALID in 1, CMD_READY out 1 and CMD_DATA in 40: the job command, packed {BIAS[39:32], DD[31:24], DC[23:16], DB[15:8], DA[7:0]}.
REQ-006 The module SHALL have ports NPU_DA, NPU_DB, NPU_DC, NPU_DD and NPU_BIAS, out 8 each: operands driven to the NPU.
REQ-007 The module SHALL have port NPU_START, out 1: the 1-cycle launch pulse.
REQ-008 The module SHALL have ports NPU_BUSY in 1, NPU_DONE in 1 and NPU_D_OUT in 8: NPU status and result.
REQ-009 The module SHALL have ports RES_VALID out 1, RES_READY in 1 and RES_DATA out 8: the result stream.
REQ-010 The module SHALL have ports BUSY out 1, JOB_CNT out 16 and ERR out 1: launcher status.

Function
REQ-011 The FSM SHALL have states IDLE, LAUNCH and WAIT, and BUSY SHALL be 1 in every state except IDLE.
REQ-012 CMD_READY SHALL be 1 only in IDLE while result FIFO occupancy < RES_DEPTH.
REQ-013 A command is accepted on CMD_VALID&&CMD_READY; that edge SHALL register all five operands and move the FSM IDLE->LAUNCH.
REQ-014 In LAUNCH, NPU_START SHALL be 1 for exactly one cycle, then the FSM SHALL move to WAIT; NPU_START SHALL be 0 in all other states.
REQ-015 NPU_DA..NPU_BIAS SHALL hold the registered values from acceptance until the next acceptance.
REQ-016 In WAIT, NPU_DONE=1 SHALL push NPU_D_OUT into the result FIFO, increment JOB_CNT and move the FSM to IDLE, all on the same edge.
REQ-017 NPU_DONE in IDLE or LAUNCH SHALL be ignored: no push and no count change.
REQ-018 NPU_BUSY SHALL be observational only and SHALL NOT affect any transition.
REQ-019 Command-to-push latency SHALL be 2 + k cycles, where k is the number of WAIT cycles before NPU_DONE; back-to-back jobs therefore need at least 3 cycles each.
REQ-020 RES_VALID SHALL equal "FIFO not empty", RES_DATA SHALL be the FIFO head, and a pop SHALL occur on RES_VALID&&RES_READY.
REQ-021 A simultaneous push and pop SHALL leave occupancy unchanged and preserve order; the push is always accepted because admission (REQ-012) guarantees space.
REQ-022 JOB_CNT SHALL wrap 0xFFFF->0x0000.

Reset
REQ-023 On RST_GLO=1 at a clock edge, the FSM SHALL go to IDLE, the FIFO SHALL empty, and all outputs SHALL be 0 (NPU_* operands, NPU_START, BUSY, ERR, JOB_CNT, RES_VALID, RES_DATA); CMD_READY SHALL be 1 from the first cycle after reset release.
REQ-024 Reset during LAUNCH or WAIT SHALL abandon the job: no push, and an NPU_DONE arriving afterwards SHALL be ignored per REQ-017.

Configuration
REQ-025 With NPU_LAUNCH_TIMEOUT_EN defined, a counter SHALL run in WAIT; if TIMEOUT_CYCLES cycles pass without NPU_DONE, the launcher SHALL set ERR (sticky until reset), return to IDLE without pushing, and leave JOB_CNT unchanged.
REQ-026 With NPU_LAUNCH_TIMEOUT_EN undefined, WAIT SHALL last indefinitely and ERR SHALL be constant 0.

Structure
REQ-027 Shared package npu_pkg SHALL hold the FSM state encoding, the CMD_DATA field offsets and width constants.
REQ-028 The result FIFO SHALL be sub-module npu_res_fifo, parameterised by depth and width 8, providing count/full/empty outputs.

Verification
REQ-029 Scenario: reset then CMD {BIAS=0x05, DD=0x04, DC=0x03, DB=0x02, DA=0x01}, NPU_DONE 5 cycles after START with D_OUT=0x3C -> one START pulse, operands stable throughout, RES_DATA=0x3C, JOB_CNT=1.
REQ-030 Scenario: 4 jobs with RES_READY=0 (RES_DEPTH=4) -> CMD_READY=0 after the 4th push; one pop -> CMD_READY=1; drain order is preserved.
REQ-031 Scenario: a pop on the same edge as a push with occupancy=2 -> occupancy stays 2 and data order is correct.
REQ-032 Scenario: NPU_DONE pulsed in IDLE -> no push and JOB_CNT unchanged.
REQ-033 Scenario: RST_GLO mid-WAIT, then NPU_DONE -> FIFO empty, JOB_CNT=0 and BUSY=0.
REQ-034 Scenario: with NPU_LAUNCH_TIMEOUT_EN and TIMEOUT_CYCLES=16, NPU_DONE withheld -> ERR=1 after 16 WAIT cycles, FSM in IDLE, no push; without the macro the launcher stays in WAIT and ERR=0.
